// File: rtl/mod_memstage.sv
// rtl/mod_memstage.sv - memory-access stage feeding the execute stage
//
// Purpose: accepts one decoded operation at a time, performs its 64-bit load
// or store over a request/grant/response port, and presents the registered
// MEM_EX bundle to execute with a valid/ready handshake.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready + in_* operation fields   upstream handshake
//   mem_req/mem_we/mem_addr/mem_wdata, mem_gnt  memory request channel
//   mem_rvalid/mem_rdata                        memory read response
//   ex_valid/ex_ready + memex                   downstream bundle
//   load_buffer, loadbuffer_done                load data for held bundle
//   memstage_active, store_memstage_active      transaction status

package mod_memstage_pkg;
  typedef struct packed {
    logic [63:0] pc_contents;
    logic [63:0] data_regA;
    logic [63:0] data_regB;
    logic [63:0] data_imm;
    logic [7:0]  ctl_opcode;
    logic [3:0]  ctl_regByte;
    logic [3:0]  ctl_rmByte;
    logic [1:0]  ctl_dep;
    logic        sim_end;
  } mem_ex_t;
endpackage

module mod_memstage
  import mod_memstage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_memop,
  input  logic [63:0] in_pc,
  input  logic [63:0] in_regA,
  input  logic [63:0] in_regB,
  input  logic [63:0] in_imm,
  input  logic [7:0]  in_opcode,
  input  logic [3:0]  in_regbyte,
  input  logic [3:0]  in_rmbyte,
  input  logic [1:0]  in_dep,
  input  logic        in_sim_end,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        ex_valid,
  input  logic        ex_ready,
  output mem_ex_t     memex,
  output logic [63:0] load_buffer,
  output logic        loadbuffer_done,
  output logic        memstage_active,
  output logic        store_memstage_active
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  mem_ex_t     memex_q, memex_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] load_buffer_q, load_buffer_d;
  logic        is_load_q, is_load_d;
  logic        is_store_q, is_store_d;

  logic        ready_int;
  logic        accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      memex_q       <= '0;
      addr_q        <= '0;
      load_buffer_q <= '0;
      is_load_q     <= 1'b0;
      is_store_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      memex_q       <= memex_d;
      addr_q        <= addr_d;
      load_buffer_q <= load_buffer_d;
      is_load_q     <= is_load_d;
      is_store_q    <= is_store_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    memex_d               = memex_q;
    addr_d                = addr_q;
    load_buffer_d         = load_buffer_q;
    is_load_d             = is_load_q;
    is_store_d            = is_store_q;
    ready_int             = 1'b0;
    mem_req               = 1'b0;
    mem_we                = 1'b0;
    mem_addr              = '0;
    mem_wdata             = '0;
    ex_valid              = 1'b0;
    loadbuffer_done       = 1'b0;
    memstage_active       = 1'b0;
    store_memstage_active = 1'b0;

    case (state_q)
      S_IDLE: ready_int = 1'b1;
      S_REQ: begin
        mem_req               = 1'b1;
        mem_we                = is_store_q;
        mem_addr              = addr_q;
        mem_wdata             = memex_q.data_regB;
        memstage_active       = 1'b1;
        store_memstage_active = is_store_q;
        if (mem_gnt) begin
          if (is_store_q) begin
            state_d = S_HOLD;
          end else if (mem_rvalid) begin
            // Response can arrive with the grant; skip WAIT entirely.
            load_buffer_d = mem_rdata;
            state_d       = S_HOLD;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        memstage_active = 1'b1;
        if (mem_rvalid) begin
          load_buffer_d = mem_rdata;
          state_d       = S_HOLD;
        end
      end
      S_HOLD: begin
        ex_valid        = 1'b1;
        loadbuffer_done = is_load_q;
        if (ex_ready) begin
          if (memex_q.sim_end) begin
            state_d = S_HALT;
          end else begin
            // Consuming the bundle frees the stage for a same-cycle accept.
            ready_int = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase

    accept = in_valid & ready_int;
    if (accept) begin
      memex_d = '{pc_contents: in_pc, data_regA: in_regA, data_regB: in_regB,
                  data_imm: in_imm, ctl_opcode: in_opcode,
                  ctl_regByte: in_regbyte, ctl_rmByte: in_rmbyte,
                  ctl_dep: in_dep, sim_end: in_sim_end};
      addr_d     = in_regA + in_imm;
      is_load_d  = (in_memop == 2'b01);
      is_store_d = (in_memop == 2'b10);
      state_d    = (in_memop == 2'b01 || in_memop == 2'b10) ? S_REQ : S_HOLD;
    end
  end

  // Held low while reset is asserted so the port reads as quiescent.
  assign in_ready    = ready_int & reset;
  assign memex       = memex_q;
  assign load_buffer = load_buffer_q;

endmodule

// File: tb/tb_mod_memstage.sv
// tb/tb_mod_memstage.sv - directed self-checking bench for mod_memstage

module tb_mod_memstage;
  import mod_memstage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_memop;
  logic [63:0] in_pc, in_regA, in_regB, in_imm;
  logic [7:0]  in_opcode;
  logic [3:0]  in_regbyte, in_rmbyte;
  logic [1:0]  in_dep;
  logic        in_sim_end;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;
  logic        ex_valid, ex_ready;
  mem_ex_t     memex;
  logic [63:0] load_buffer;
  logic        loadbuffer_done, memstage_active, store_memstage_active;

  int total = 0;
  int bad   = 0;
  int act_cnt;

  always #5 clk = ~clk;

  mod_memstage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_memop(in_memop),
    .in_pc(in_pc), .in_regA(in_regA), .in_regB(in_regB), .in_imm(in_imm),
    .in_opcode(in_opcode), .in_regbyte(in_regbyte), .in_rmbyte(in_rmbyte),
    .in_dep(in_dep), .in_sim_end(in_sim_end),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .memex(memex),
    .load_buffer(load_buffer), .loadbuffer_done(loadbuffer_done),
    .memstage_active(memstage_active), .store_memstage_active(store_memstage_active)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] memop, input logic [7:0] opc,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] imm, input logic se);
    in_valid   = 1'b1;
    in_memop   = memop;
    in_opcode  = opc;
    in_regA    = a;
    in_regB    = b;
    in_imm     = imm;
    in_pc      = a + 64'd1;
    in_sim_end = se;
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 0; in_memop = 0; in_pc = 0; in_regA = 0; in_regB = 0; in_imm = 0;
    in_opcode = 0; in_regbyte = 4'h3; in_rmbyte = 4'h5; in_dep = 2'b10; in_sim_end = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; ex_ready = 0;

    tick(); tick();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_memex", memex, 0);
    chk("rst_load_buffer", load_buffer, 0);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Non-memory op, then a back-to-back second op.
    drive_op(2'b00, 8'h31, 64'd5, 64'd3, 64'd0, 1'b0);
    ex_ready = 1'b1;
    tick();
    chk("nm_ex_valid", ex_valid, 1);
    chk("nm_regA", memex.data_regA, 64'd5);
    chk("nm_regB", memex.data_regB, 64'd3);
    chk("nm_opcode", memex.ctl_opcode, 8'h31);
    chk("nm_regbyte", memex.ctl_regByte, 4'h3);
    chk("nm_lb_done", loadbuffer_done, 0);
    chk("nm_in_ready_b2b", in_ready, 1);
    drive_op(2'b11, 8'h32, 64'd7, 64'd0, 64'd0, 1'b0);
    tick();
    chk("b2b_ex_valid", ex_valid, 1);
    chk("b2b_regA", memex.data_regA, 64'd7);
    chk("b2b_active", memstage_active, 0);
    in_valid = 1'b0;
    tick();
    chk("b2b_idle_ex_valid", ex_valid, 0);

    // Load: gnt in second REQ cycle, rvalid three cycles later.
    drive_op(2'b01, 8'h8B, 64'h1000, 64'h0, 64'h100, 1'b0);
    ex_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    act_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      mem_gnt    = (i == 1);
      mem_rvalid = (i == 4) || (i == 0);
      mem_rdata  = (i == 4) ? 64'hDEADBEEF : 64'h1111;
      if (memstage_active) act_cnt++;
      if (i == 0) begin
        chk("ld_mem_req", mem_req, 1);
        chk("ld_mem_addr", mem_addr, 64'h1100);
        chk("ld_mem_we", mem_we, 0);
        chk("ld_store_active", store_memstage_active, 0);
      end
      if (i == 2) chk("ld_wait_req", mem_req, 0);
      tick();
    end
    chk("ld_active_cycles", act_cnt, 5);
    chk("ld_ex_valid", ex_valid, 1);
    chk("ld_buffer", load_buffer, 64'hDEADBEEF);
    chk("ld_lb_done", loadbuffer_done, 1);

    // Stalled HOLD keeps everything stable.
    for (int i = 0; i < 4; i++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_regA", memex.data_regA, 64'h1000);
      chk("stall_buffer", load_buffer, 64'hDEADBEEF);
      tick();
    end

    // Consume and accept a store in the same cycle; address wraps.
    drive_op(2'b10, 8'h89, 64'hFFFF_FFFF_FFFF_FFF8, 64'h42, 64'h10, 1'b0);
    ex_ready = 1'b1;
    #1;
    chk("st_accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    ex_ready = 1'b0;
    mem_gnt  = 1'b1;
    chk("st_mem_req", mem_req, 1);
    chk("st_mem_addr", mem_addr, 64'h8);
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_wdata", mem_wdata, 64'h42);
    chk("st_store_active", store_memstage_active, 1);
    chk("st_ex_valid_req", ex_valid, 0);
    tick();
    mem_gnt = 1'b0;
    chk("st_ex_valid", ex_valid, 1);
    chk("st_store_active_off", store_memstage_active, 0);
    chk("st_lb_done", loadbuffer_done, 0);
    chk("st_buffer_kept", load_buffer, 64'hDEADBEEF);

    // Load with gnt and rvalid together.
    drive_op(2'b01, 8'h8B, 64'h20, 64'h0, 64'h0, 1'b0);
    ex_ready = 1'b1;
    tick();
    in_valid   = 1'b0;
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h7;
    chk("ld0_mem_addr", mem_addr, 64'h20);
    chk("ld0_ex_valid_req", ex_valid, 0);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("ld0_ex_valid", ex_valid, 1);
    chk("ld0_buffer", load_buffer, 64'h7);
    chk("ld0_lb_done", loadbuffer_done, 1);
    chk("ld0_active", memstage_active, 0);
    tick();
    chk("ld0_idle", ex_valid, 0);

    // Reset in WAIT; late rvalid ignored.
    drive_op(2'b01, 8'h8B, 64'h40, 64'h0, 64'h0, 1'b0);
    ex_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    mem_gnt  = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("rw_wait_active", memstage_active, 1);
    chk("rw_wait_req", mem_req, 0);
    reset = 1'b0;
    #1;
    chk("rw_active", memstage_active, 0);
    chk("rw_memex", memex, 0);
    chk("rw_buffer", load_buffer, 0);
    chk("rw_ex_valid", ex_valid, 0);
    tick();
    reset      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h55;
    tick();
    mem_rvalid = 1'b0;
    chk("rw_late_buffer", load_buffer, 0);
    chk("rw_late_ex_valid", ex_valid, 0);
    chk("rw_late_in_ready", in_ready, 1);

    // sim_end halts the stage until reset.
    drive_op(2'b00, 8'hFF, 64'h9, 64'h0, 64'h0, 1'b1);
    ex_ready = 1'b1;
    tick();
    drive_op(2'b00, 8'h01, 64'hA, 64'h0, 64'h0, 1'b0);
    chk("se_ex_valid", ex_valid, 1);
    chk("se_sim_end", memex.sim_end, 1);
    chk("se_in_ready", in_ready, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("halt_in_ready", in_ready, 0);
      chk("halt_ex_valid", ex_valid, 0);
      tick();
    end
    chk("halt_regA", memex.data_regA, 64'h9);
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("halt_reset_ready", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
